// File: rtl/adder24_arbiter.sv
// Round-robin scheduler sharing one dual-lane adder among NREQ requesters, tagging each sum back to its owner.
// Latency: transfer edge to RESx_VALID is ADD_LAT+2 cycles; up to two grants and two results per cycle.
// Backpressure: REQ_READY is the combinational grant; results are never stalled.
module adder24_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 24,
    parameter int ADD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*DW-1:0] REQ_A,
    input  logic [NREQ*DW-1:0] REQ_B,
    output logic [DW-1:0]     AIN1,
    output logic [DW-1:0]     AIN2,
    output logic [DW-1:0]     BIN1,
    output logic [DW-1:0]     BIN2,
    input  logic [DW:0]       OUT1,
    input  logic [DW:0]       OUT2,
    output logic              RES1_VALID,
    output logic              RES2_VALID,
    output logic [2:0]        RES1_ID,
    output logic [2:0]        RES2_ID,
    output logic [DW:0]       RES1_DATA,
    output logic [DW:0]       RES2_DATA,
    output logic              BUSY
);
    localparam int IW = 3;
    localparam int PW = IW + 1;

    logic [IW-1:0] ptr;
    logic [7:0]    vld_pad;
    logic [PW-1:0] idx;
    logic          a_hit, b_hit;
    logic [IW-1:0] a_id, b_id;
    logic [DW-1:0] a_op1, a_op2, b_op1, b_op2;

    // Operand-stage tag plus a tag pipe that tracks the adder's input register and its ADD_LAT stages.
    logic          op_a_vld, op_b_vld;
    logic [IW-1:0] op_a_id, op_b_id;
    logic [ADD_LAT:0] tag_a_vld, tag_b_vld;
    logic [IW-1:0] tag_a_id [ADD_LAT+1];
    logic [IW-1:0] tag_b_id [ADD_LAT+1];

    assign vld_pad = 8'(REQ_VALID);

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
        return ({1'b0, id} == PW'(NREQ - 1)) ? '0 : id + IW'(1);
    endfunction

    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_id  = '0;
        b_id  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + PW'(k);
            if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
            if (vld_pad[idx[IW-1:0]] && !RST) begin
                if (!a_hit) begin
                    a_hit = 1'b1;
                    a_id  = idx[IW-1:0];
                end else if (!b_hit) begin
                    b_hit = 1'b1;
                    b_id  = idx[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        a_op1 = '0;
        a_op2 = '0;
        b_op1 = '0;
        b_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (a_hit && a_id == IW'(i)) begin
                REQ_READY[i] = 1'b1;
                a_op1 = REQ_A[i*DW +: DW];
                a_op2 = REQ_B[i*DW +: DW];
            end
            if (b_hit && b_id == IW'(i)) begin
                REQ_READY[i] = 1'b1;
                b_op1 = REQ_A[i*DW +: DW];
                b_op2 = REQ_B[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr        <= '0;
            AIN1       <= '0;
            AIN2       <= '0;
            BIN1       <= '0;
            BIN2       <= '0;
            op_a_vld   <= 1'b0;
            op_b_vld   <= 1'b0;
            op_a_id    <= '0;
            op_b_id    <= '0;
            tag_a_vld  <= '0;
            tag_b_vld  <= '0;
            for (int j = 0; j <= ADD_LAT; j++) begin
                tag_a_id[j] <= '0;
                tag_b_id[j] <= '0;
            end
            RES1_VALID <= 1'b0;
            RES2_VALID <= 1'b0;
            RES1_ID    <= '0;
            RES2_ID    <= '0;
            RES1_DATA  <= '0;
            RES2_DATA  <= '0;
        end else begin
            if (b_hit)      ptr <= next_ptr(b_id);
            else if (a_hit) ptr <= next_ptr(a_id);

            // Idle lanes load zero because the muxed operands default to zero.
            AIN1 <= a_op1;
            AIN2 <= a_op2;
            BIN1 <= b_op1;
            BIN2 <= b_op2;

            op_a_vld  <= a_hit;
            op_b_vld  <= b_hit;
            op_a_id   <= a_id;
            op_b_id   <= b_id;
            tag_a_vld <= {tag_a_vld[ADD_LAT-1:0], op_a_vld};
            tag_b_vld <= {tag_b_vld[ADD_LAT-1:0], op_b_vld};
            tag_a_id[0] <= op_a_id;
            tag_b_id[0] <= op_b_id;
            for (int j = 1; j <= ADD_LAT; j++) begin
                tag_a_id[j] <= tag_a_id[j-1];
                tag_b_id[j] <= tag_b_id[j-1];
            end

            RES1_VALID <= tag_a_vld[ADD_LAT];
            RES2_VALID <= tag_b_vld[ADD_LAT];
            if (tag_a_vld[ADD_LAT]) begin
                RES1_DATA <= OUT1;
                RES1_ID   <= tag_a_id[ADD_LAT];
            end
            if (tag_b_vld[ADD_LAT]) begin
                RES2_DATA <= OUT2;
                RES2_ID   <= tag_b_id[ADD_LAT];
            end
        end
    end

    assign BUSY = op_a_vld | op_b_vld | (|tag_a_vld) | (|tag_b_vld);

endmodule

// File: tb/tb_adder24_arbiter.sv
// Bench for adder24_arbiter: vector table, directed corner sequences, then random traffic
// against a queue-based reference of grants and results; includes a behavioural dual-lane adder.
module tb_adder24_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 24;
    localparam int ADD_LAT = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     REQ_VALID;
    logic [NREQ-1:0]     REQ_READY;
    logic [NREQ*DW-1:0]  REQ_A, REQ_B;
    logic [DW-1:0]       AIN1, AIN2, BIN1, BIN2;
    logic [DW:0]         OUT1, OUT2;
    logic                RES1_VALID, RES2_VALID;
    logic [2:0]          RES1_ID, RES2_ID;
    logic [DW:0]         RES1_DATA, RES2_DATA;
    logic                BUSY;

    always #5 CLK = ~CLK;

    adder24_arbiter #(.NREQ(NREQ), .DW(DW), .ADD_LAT(ADD_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .AIN1(AIN1), .AIN2(AIN2), .BIN1(BIN1), .BIN2(BIN2),
        .OUT1(OUT1), .OUT2(OUT2),
        .RES1_VALID(RES1_VALID), .RES2_VALID(RES2_VALID),
        .RES1_ID(RES1_ID), .RES2_ID(RES2_ID),
        .RES1_DATA(RES1_DATA), .RES2_DATA(RES2_DATA),
        .BUSY(BUSY)
    );

    // Adder model: input register followed by ADD_LAT pipeline stages.
    logic [DW:0] pa [ADD_LAT+1];
    logic [DW:0] pb [ADD_LAT+1];
    always @(posedge CLK) begin
        pa[0] <= {1'b0, AIN1} + {1'b0, AIN2};
        pb[0] <= {1'b0, BIN1} + {1'b0, BIN2};
        for (int j = 1; j <= ADD_LAT; j++) begin
            pa[j] <= pa[j-1];
            pb[j] <= pb[j-1];
        end
    end
    assign OUT1 = pa[ADD_LAT];
    assign OUT2 = pb[ADD_LAT];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [DW:0] sum;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    int   m_ptr = 0;
    logic [NREQ-1:0] granted;
    logic [DW-1:0] op_a [NREQ];
    logic [DW-1:0] op_b [NREQ];

    function automatic logic [DW:0] add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Reference: round-robin scan from m_ptr, results due ADD_LAT+2 edges after the transfer edge.
    task automatic model_cycle();
        int ga, gb;
        logic [NREQ-1:0] exp_rdy;
        res_t r;
        ga = -1;
        gb = -1;
        if (!RST) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (REQ_VALID[i]) begin
                    if (ga < 0) ga = i;
                    else if (gb < 0) gb = i;
                end
            end
        end
        exp_rdy = '0;
        if (ga >= 0) exp_rdy[ga] = 1'b1;
        if (gb >= 0) exp_rdy[gb] = 1'b1;
        check("req_ready", 32'(REQ_READY), 32'(exp_rdy));

        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front();
            check("res1_valid", 32'(RES1_VALID), 32'd1);
            check("res1_id", 32'(RES1_ID), 32'(r.id));
            check("res1_data", 32'(RES1_DATA), 32'(r.sum));
        end else begin
            check("res1_idle", 32'(RES1_VALID), 32'd0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front();
            check("res2_valid", 32'(RES2_VALID), 32'd1);
            check("res2_id", 32'(RES2_ID), 32'(r.id));
            check("res2_data", 32'(RES2_DATA), 32'(r.sum));
        end else begin
            check("res2_idle", 32'(RES2_VALID), 32'd0);
        end
        check("busy", 32'(BUSY), 32'((qa.size() + qb.size()) != 0));

        granted = REQ_READY & REQ_VALID;
        if (RST) begin
            m_ptr = 0;
            qa.delete();
            qb.delete();
        end else begin
            if (ga >= 0) qa.push_back('{cyc + ADD_LAT + 3, ga, add(REQ_A[ga*DW +: DW], REQ_B[ga*DW +: DW])});
            if (gb >= 0) qb.push_back('{cyc + ADD_LAT + 3, gb, add(REQ_A[gb*DW +: DW], REQ_B[gb*DW +: DW])});
            if (gb >= 0)      m_ptr = (gb + 1) % NREQ;
            else if (ga >= 0) m_ptr = (ga + 1) % NREQ;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        model_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            REQ_A[i*DW +: DW] = op_a[i];
            REQ_B[i*DW +: DW] = op_b[i];
        end
    endtask

    function automatic logic [DW-1:0] rnd_op();
        return ($urandom_range(3, 0) == 0) ? {DW{1'b1}} : DW'($urandom);
    endfunction

    task automatic reload_granted();
        for (int i = 0; i < NREQ; i++)
            if (granted[i]) begin
                op_a[i] = rnd_op();
                op_b[i] = rnd_op();
            end
        drive_ops();
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2, 24'd8299999,  24'd1010010,  25'd9310009};
        vecs[1] = '{0, 24'd16777215, 24'd16777215, 25'd33554430};
        vecs[2] = '{1, 24'd0,        24'd0,        25'd0};
        vecs[3] = '{3, 24'd1,        24'd16777215, 25'd16777216};
        vecs[4] = '{2, 24'd123456,   24'd654321,   25'd777777};

        // Reset held with every requester valid.
        RST = 1'b1;
        REQ_VALID = '1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = DW'(32'h100 * (i + 1));
            op_b[i] = DW'(32'h11 * (i + 1));
        end
        drive_ops();
        tick();
        #3;
        check("rst_ready", 32'(REQ_READY), 32'd0);
        check("rst_ain", 32'({AIN1, AIN2} != 0), 32'd0);
        check("rst_bin", 32'({BIN1, BIN2} != 0), 32'd0);
        check("rst_res", 32'({RES1_VALID, RES2_VALID, RES1_ID, RES2_ID, RES1_DATA, RES2_DATA} != 0), 32'd0);
        tick();
        RST = 1'b0;

        // Saturated traffic: grants alternate (0,1),(2,3).
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] pat;
            pat = (k % 2 == 1) ? 4'b1100 : 4'b0011;
            #3;
            check("rr_pattern", 32'(REQ_READY), 32'(pat));
            if (k > 0) check("busy_full", 32'(BUSY), 32'd1);
            tick();
            reload_granted();
        end
        REQ_VALID = '0;
        for (int k = 0; k < ADD_LAT + 4; k++) tick();

        // Single-requester vectors on lane A.
        for (int v = 0; v < 5; v++) begin
            op_a[vecs[v].id] = vecs[v].a;
            op_b[vecs[v].id] = vecs[v].b;
            drive_ops();
            REQ_VALID = '0;
            REQ_VALID[vecs[v].id] = 1'b1;
            tick();
            REQ_VALID = '0;
            for (int k = 0; k < ADD_LAT + 2; k++) tick();
            #3;
            check("vec_valid", 32'(RES1_VALID), 32'd1);
            check("vec_id", 32'(RES1_ID), 32'(vecs[v].id));
            check("vec_data", 32'(RES1_DATA), 32'(vecs[v].sum));
            check("vec_lane_b", 32'(RES2_VALID), 32'd0);
            tick();
            #3;
            check("vec_hold", 32'(RES1_DATA), 32'(vecs[v].sum));
            tick();
        end

        // Pointer at 2 with only req1 and req3: req3 on lane A, req1 on lane B, twice.
        REQ_VALID = 4'b0010;
        tick();
        REQ_VALID = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] ea, eb;
            ea = op_a[3];
            eb = op_a[1];
            #3;
            check("ptr2_ready", 32'(REQ_READY), 32'b1010);
            tick();
            check("ptr2_lane_a", 32'(AIN1), 32'(ea));
            check("ptr2_lane_b", 32'(BIN1), 32'(eb));
            reload_granted();
        end
        REQ_VALID = '0;
        for (int k = 0; k < ADD_LAT + 4; k++) tick();

        // Two grant cycles, then a one-cycle reset discards them.
        REQ_VALID = '1;
        tick();
        reload_granted();
        tick();
        reload_granted();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ_VALID = '0;
        for (int k = 0; k < ADD_LAT + 4; k++) begin
            #3;
            check("flush_res", 32'({RES1_VALID, RES2_VALID}), 32'd0);
            check("flush_busy", 32'(BUSY), 32'd0);
            tick();
        end
        REQ_VALID = '1;
        #3;
        check("post_rst_grant", 32'(REQ_READY), 32'b0011);
        tick();
        reload_granted();

        // Random traffic with hold-until-granted requesters and rare resets.
        for (int k = 0; k < 400; k++) begin
            RST = ($urandom_range(63, 0) == 0);
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) REQ_VALID[i] = 1'b0;
                if (!REQ_VALID[i] && $urandom_range(1, 0) == 1) begin
                    REQ_VALID[i] = 1'b1;
                    op_a[i] = rnd_op();
                    op_b[i] = rnd_op();
                end
            end
            drive_ops();
        end
        RST = 1'b0;
        REQ_VALID = '0;
        for (int k = 0; k < ADD_LAT + 4; k++) tick();
        check("drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder24_arbiter.md
Name: adder24_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one dual-lane dsp_adder24 (lanes A and B, 24-bit operands, 25-bit sums) among NREQ filter requesters.
- Each cycle it grants up to two requesters, one per lane, and drives their operands onto the adder inputs.
- It tracks each in-flight addition with a requester tag and returns each sum to the requester it belongs to.
- Sits between the spatial-filter tap units and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 24, operand width; adder sum width is DW+1.
- ADD_LAT, 2, cycles from operands on AIN*/BIN* to a valid sum on OUT1/OUT2 (dsp_adder24 pipeline depth; 1..8).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- REQ_VALID  in  NREQ  bit i: requester i has an operand pair.
- REQ_READY  out  NREQ  bit i: requester i granted this cycle (combinational).
- REQ_A  in  NREQ*DW  operand A; requester i at [i*DW +: DW].
- REQ_B  in  NREQ*DW  operand B; same packing as REQ_A.
- AIN1, AIN2  out  DW  registered lane-A operands to the adder.
- BIN1, BIN2  out  DW  registered lane-B operands to the adder.
- OUT1, OUT2  in  DW+1  lane A / lane B sums from the adder.
- RES1_VALID, RES2_VALID  out  1  lane A / lane B result valid, one-cycle pulse.
- RES1_ID, RES2_ID  out  3  requester index owning the result.
- RES1_DATA, RES2_DATA  out  DW+1  registered sum.
- BUSY  out  1  high when any operation is in flight.

Behaviour:
- Handshake and grant:
  - A transfer happens on the rising edge ending a cycle where REQ_VALID[i] and REQ_READY[i] are both high.
  - REQ_VALID must hold, with stable operands, until the transfer. No result backpressure.
- Round-robin selection:
  - Scan requesters from PTR upward, modulo NREQ.
  - The first valid requester gets lane A; the second distinct valid requester gets lane B.
  - At most 2 READY bits are high in a cycle. No requester is granted both lanes.
  - One valid requester: lane A only; lane B idles.
- PTR update:
  - After a cycle with any grant, PTR becomes (index of last granted requester + 1) mod NREQ.
  - With no grant, PTR holds.
  - Starvation-free: each continuously valid requester is granted within ceil(NREQ/2) cycles.
- Operand stage:
  - At the transfer edge, granted operands load into AIN1/AIN2 (lane A) and BIN1/BIN2 (lane B).
  - An idle lane loads 0.
- Tag pipeline:
  - Per lane, a shift register of depth ADD_LAT+1 carries {valid, id}, aligned with the operand stage and the adder.
- Result stage:
  - When a lane's tag emerges valid, OUTx is registered into RESx_DATA, RESx_ID takes the tag id, and RESx_VALID pulses.
  - Latency from transfer edge to RESx_VALID high is exactly ADD_LAT+2 cycles. Throughput is 2 results per cycle.
  - When RESx_VALID is low, RESx_DATA and RESx_ID hold their last values.
- Arithmetic: the sum is the unsigned 25-bit adder output, passed through unmodified (carry preserved, no saturation).
- BUSY is the OR of all tag-valid bits, including the operand stage.
- Reset (RST high at an edge):
  - PTR=0 and all tag bits cleared.
  - AIN*, BIN*, RES*_DATA, RES*_ID and RES*_VALID all 0; BUSY=0.
  - REQ_READY forced to 0 while RST is high.
  - In-flight operations are discarded: no RES*_VALID until after a new transfer.
- Simultaneous events: a transfer and a result in the same cycle are independent. RST overrides everything.

Test Plan:
1. RST high for 2 cycles with REQ_VALID=4'b1111 -> REQ_READY=0 and all outputs 0. In the first cycle after release, READY=4'b0011 (req0 on lane A, req1 on lane B).
2. Only req2 valid, A=8299999, B=1010010 -> exactly 4 cycles after the transfer (ADD_LAT=2): RES1_VALID=1, RES1_ID=2, RES1_DATA=9310009; RES2_VALID stays 0.
3. req0 A=16777215, B=16777215 -> RES1_DATA=33554430 (25'h1FFFFFE), carry preserved.
4. All 4 requesters valid for 8 cycles, each sending distinct operands -> grants alternate (0,1),(2,3). The RES ID stream matches grant order with correct sums. Each requester gets 1 grant per 2 cycles; BUSY is high throughout.
5. PTR=2 with only req1 and req3 valid -> lane A=req3, lane B=req1. Next PTR=2, so the same assignment repeats on the next cycle.
6. Grants in 2 consecutive cycles, then RST pulsed for 1 cycle -> no RES*_VALID afterwards, BUSY=0. The first post-reset grant starts at req0.
